fault_supervisor_n: RTL and testbench

- Parametrised N-channel successor to the single 4-input fault FSM.
- Each channel has its own mask, persistence (debounce) counter, saturating event counter and shutdown-enable bit.
- One global supervisor FSM escalates NORMAL -> WARNING -> FAULT -> SHUTDOWN, with auto-recovery from WARNING and an explicit clear for FAULT.
- Sits between the analog comparator flags (OV/UV/OT/UC and any added channels) and the power-stage enable logic.

---
 rtl/fault_pkg.sv | 27 ++
 rtl/fault_chan_qual.sv | 47 ++++
 rtl/fault_supervisor_n.sv | 127 ++++++++++++
 tb/tb_fault_supervisor_n.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/fault_pkg.sv
// Shared types and helpers for the N-channel fault supervisor.
// Latency: n/a (types, constants and a pure combinational function only).
// Backpressure: none; nothing here holds state.
package fault_pkg;

  typedef enum logic [1:0] {
    ST_NORMAL   = 2'd0,
    ST_WARNING  = 2'd1,
    ST_FAULT    = 2'd2,
    ST_SHUTDOWN = 2'd3
  } state_t;

  localparam int ID_W   = 4;
  // Widest channel vector an ID_W-bit id can name (id 0 means "none").
  localparam int MAX_CH = 15;

  // Id of the lowest set bit, 1-based; 0 when no bit is set.
  function automatic logic [ID_W-1:0] lowest_id(input logic [MAX_CH-1:0] v);
    logic [ID_W-1:0] id;
    id = '0;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (v[i]) id = ID_W'(i + 1);
    end
    return id;
  endfunction

endpackage

// File: rtl/fault_chan_qual.sv
// One fault channel: masking, persistence count and saturating event count.
// Latency: pcnt/evt_cnt registered, 1 cycle after the qualified flag; ge_* flags decode registered pcnt.
// Backpressure: none; the flag is sampled every cycle.
module fault_chan_qual #(
  parameter int CNT_W     = 8,
  parameter int EVT_W     = 8,
  parameter int WARN_CYC  = 4,
  parameter int FAULT_CYC = 16,
  parameter int SHUT_CYC  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flt,
  input  logic             msk,
  output logic             q,
  output logic [CNT_W-1:0] pcnt,
  output logic             ge_warn,
  output logic             ge_fault,
  output logic             ge_shut,
  output logic [EVT_W-1:0] evt_cnt
);

  localparam logic [CNT_W-1:0] WARN_V    = CNT_W'(WARN_CYC);
  localparam logic [CNT_W-1:0] WARN_M1   = CNT_W'(WARN_CYC - 1);
  localparam logic [CNT_W-1:0] FAULT_V   = CNT_W'(FAULT_CYC);
  localparam logic [CNT_W-1:0] SHUT_V    = CNT_W'(SHUT_CYC);
  localparam logic [EVT_W-1:0] EVT_MAX   = '1;

  assign q        = flt & ~msk;
  assign ge_warn  = (pcnt >= WARN_V);
  assign ge_fault = (pcnt >= FAULT_V);
  assign ge_shut  = (pcnt >= SHUT_V);

  // Persistence: run length of consecutive qualified cycles, saturating at the shutdown threshold.
  always_ff @(posedge clk) begin
    if (rst)                 pcnt <= '0;
    else if (!q)             pcnt <= '0;
    else if (pcnt != SHUT_V) pcnt <= pcnt + 1'b1;
  end

  // One event per run that crosses the warning threshold; never wraps, only rst clears it.
  always_ff @(posedge clk) begin
    if (rst)                                            evt_cnt <= '0;
    else if (q && (pcnt == WARN_M1) && (evt_cnt != EVT_MAX)) evt_cnt <= evt_cnt + 1'b1;
  end

endmodule

// File: rtl/fault_supervisor_n.sv
// N-channel fault supervisor: NORMAL -> WARNING -> FAULT -> SHUTDOWN escalation for the power stage.
// Latency: all outputs registered; state reacts one cycle after pcnt crosses a threshold.
// Backpressure: none; flags and clear pulses are sampled every cycle.
module fault_supervisor_n
  import fault_pkg::*;
#(
  parameter int              N_CH        = 4,
  parameter int              CNT_W       = 8,
  parameter int              EVT_W       = 8,
  parameter int              WARN_CYC    = 4,
  parameter int              FAULT_CYC   = 16,
  parameter int              SHUT_CYC    = 32,
  parameter int              RECOVER_CYC = 8,
  parameter logic [N_CH-1:0] SHUT_EN     = '1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       flt_in,
  input  logic [N_CH-1:0]       mask,
  input  logic                  clear_warning,
  input  logic                  clear_fault,
  output logic [1:0]            state,
  output logic                  warn,
  output logic                  fault,
  output logic                  shutdown,
  output logic [ID_W-1:0]       active_fault_id,
  output logic [ID_W-1:0]       first_fault_id,
  output logic [N_CH*EVT_W-1:0] evt_cnt
);

  if (!(N_CH >= 1 && N_CH <= MAX_CH && WARN_CYC >= 1 && WARN_CYC < FAULT_CYC &&
        FAULT_CYC < SHUT_CYC && SHUT_CYC <= (1 << CNT_W) - 1 && RECOVER_CYC >= 1)) begin : g_bad_param
    $error("fault_supervisor_n: illegal channel count or threshold ordering");
  end

  localparam int               REC_W   = $clog2(RECOVER_CYC + 1);
  localparam logic [REC_W-1:0] REC_M1  = REC_W'(RECOVER_CYC - 1);
  localparam logic [CNT_W-1:0] WARN_V  = CNT_W'(WARN_CYC);

  logic [N_CH-1:0]  q_v, ge_warn_v, ge_fault_v, ge_shut_v;
  logic [CNT_W-1:0] pcnt_a [N_CH];

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    fault_chan_qual #(
      .CNT_W(CNT_W), .EVT_W(EVT_W), .WARN_CYC(WARN_CYC),
      .FAULT_CYC(FAULT_CYC), .SHUT_CYC(SHUT_CYC)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .flt     (flt_in[i]),
      .msk     (mask[i]),
      .q       (q_v[i]),
      .pcnt    (pcnt_a[i]),
      .ge_warn (ge_warn_v[i]),
      .ge_fault(ge_fault_v[i]),
      .ge_shut (ge_shut_v[i]),
      .evt_cnt (evt_cnt[i*EVT_W +: EVT_W])
    );
  end

  state_t           st_q, st_d;
  logic [REC_W-1:0] rec_q, rec_d;
  logic [ID_W-1:0]  first_d, id_comb;
  logic             any_q, shut_hit, fault_hit, warn_hit, all_below_warn, recover_hit;

  assign state = st_q;

  // Next state, recovery count and first-fault id from registered pcnt and this cycle's inputs.
  always_comb begin
    st_d           = st_q;
    rec_d          = '0;
    first_d        = first_fault_id;
    all_below_warn = 1'b1;
    for (int i = 0; i < N_CH; i++) begin
      if (pcnt_a[i] >= WARN_V) all_below_warn = 1'b0;
    end
    any_q       = |q_v;
    shut_hit    = |(ge_shut_v & SHUT_EN);
    fault_hit   = |ge_fault_v;
    warn_hit    = |ge_warn_v;
    id_comb     = lowest_id(MAX_CH'(ge_warn_v));
    recover_hit = (st_q == ST_WARNING) && !any_q && (rec_q == REC_M1);

    if (st_q != ST_SHUTDOWN && shut_hit) begin
      st_d = ST_SHUTDOWN;
    end else begin
      unique case (st_q)
        ST_NORMAL:   if (fault_hit) st_d = ST_FAULT;
                     else if (warn_hit) st_d = ST_WARNING;
        ST_WARNING:  if (fault_hit) st_d = ST_FAULT;
                     else if ((clear_warning && all_below_warn) || recover_hit) st_d = ST_NORMAL;
        ST_FAULT:    if (clear_fault && !any_q) st_d = ST_NORMAL;
        ST_SHUTDOWN: st_d = ST_SHUTDOWN;
        default:     st_d = ST_NORMAL;
      endcase
    end

    // Recovery only counts clean cycles spent continuously in WARNING.
    if (st_q == ST_WARNING && st_d == ST_WARNING && !any_q) rec_d = rec_q + 1'b1;

    // Capture the id that becomes active on this same edge, not the lagging registered copy.
    if (st_q == ST_NORMAL && st_d != ST_NORMAL) first_d = id_comb;
    else if (st_d == ST_NORMAL)                 first_d = '0;
  end

  // Register state, decoded flags, ids and the recovery counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q            <= ST_NORMAL;
      warn            <= 1'b0;
      fault           <= 1'b0;
      shutdown        <= 1'b0;
      active_fault_id <= '0;
      first_fault_id  <= '0;
      rec_q           <= '0;
    end else begin
      st_q            <= st_d;
      warn            <= (st_d == ST_WARNING);
      fault           <= (st_d == ST_FAULT);
      shutdown        <= (st_d == ST_SHUTDOWN);
      active_fault_id <= id_comb;
      first_fault_id  <= first_d;
      rec_q           <= rec_d;
    end
  end

endmodule

// File: tb/tb_fault_supervisor_n.sv
// Bench for fault_supervisor_n: two instances (all channels shutdown-capable, and channel 3 not).
// Latency: outputs sampled 1 time unit after each rising edge and compared with a run-length model.
// Backpressure: n/a.
module tb_fault_supervisor_n;

  localparam int WARN = 4, FLT = 16, SHUT = 32, REC = 8, EMAX = 255;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] flt_in = '0, mask = '0;
  logic       cw = 1'b0, cf = 1'b0;

  logic [1:0]  st_o    [2];
  logic        warn_o  [2], fault_o [2], shut_o [2];
  logic [3:0]  act_o   [2], first_o [2];
  logic [31:0] evt_o   [2];

  int total = 0, bad = 0;

  // Model: per instance, run length and event count per channel, plus supervisor state.
  int m_run [2][4];
  int m_evt [2][4];
  int m_st [2], m_rec [2], m_act [2], m_first [2];

  always #5 clk = ~clk;

  fault_supervisor_n u_dut0 (
    .clk(clk), .rst(rst), .flt_in(flt_in), .mask(mask),
    .clear_warning(cw), .clear_fault(cf),
    .state(st_o[0]), .warn(warn_o[0]), .fault(fault_o[0]), .shutdown(shut_o[0]),
    .active_fault_id(act_o[0]), .first_fault_id(first_o[0]), .evt_cnt(evt_o[0])
  );

  fault_supervisor_n #(.SHUT_EN(4'b0111)) u_dut1 (
    .clk(clk), .rst(rst), .flt_in(flt_in), .mask(mask),
    .clear_warning(cw), .clear_fault(cf),
    .state(st_o[1]), .warn(warn_o[1]), .fault(fault_o[1]), .shutdown(shut_o[1]),
    .active_fault_id(act_o[1]), .first_fault_id(first_o[1]), .evt_cnt(evt_o[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit shut_ok(input int k, input int ch);
    return (k == 0) || (ch != 3);
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step(input logic r, input logic [3:0] f, input logic [3:0] m,
                            input logic c_w, input logic c_f);
    for (int k = 0; k < 2; k++) begin
      int ns, id;
      bit any_shut, any_fault, any_warn, anyq;
      if (r) begin
        for (int i = 0; i < 4; i++) begin m_run[k][i] = 0; m_evt[k][i] = 0; end
        m_st[k] = 0; m_rec[k] = 0; m_act[k] = 0; m_first[k] = 0;
      end else begin
        id = 0; any_shut = 0; any_fault = 0; any_warn = 0; anyq = 0;
        for (int i = 3; i >= 0; i--) begin
          if (m_run[k][i] >= WARN) begin any_warn = 1; id = i + 1; end
          if (m_run[k][i] >= FLT) any_fault = 1;
          if (m_run[k][i] >= SHUT && shut_ok(k, i)) any_shut = 1;
          if (f[i] && !m[i]) anyq = 1;
        end
        ns = m_st[k];
        if (m_st[k] != 3 && any_shut) ns = 3;
        else if (m_st[k] == 0) ns = any_fault ? 2 : (any_warn ? 1 : 0);
        else if (m_st[k] == 1) begin
          if (any_fault) ns = 2;
          else if ((c_w && !any_warn) || (!anyq && m_rec[k] == REC - 1)) ns = 0;
        end else if (m_st[k] == 2) begin
          if (c_f && !anyq) ns = 0;
        end
        if (m_st[k] == 0 && ns != 0) m_first[k] = id;
        else if (ns == 0)            m_first[k] = 0;
        m_rec[k] = (m_st[k] == 1 && ns == 1 && !anyq) ? m_rec[k] + 1 : 0;
        m_act[k] = id;
        for (int i = 0; i < 4; i++) begin
          if (f[i] && !m[i]) begin
            if (m_run[k][i] == WARN - 1 && m_evt[k][i] < EMAX) m_evt[k][i]++;
            if (m_run[k][i] < SHUT) m_run[k][i]++;
          end else begin
            m_run[k][i] = 0;
          end
        end
        m_st[k] = ns;
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      logic [31:0] e;
      e = '0;
      for (int i = 0; i < 4; i++) e[i*8 +: 8] = 8'(m_evt[k][i]);
      chk($sformatf("state%0d", k), 32'(st_o[k]), 32'(m_st[k]));
      chk($sformatf("flags%0d", k), {29'd0, warn_o[k], fault_o[k], shut_o[k]},
          {29'd0, m_st[k] == 1, m_st[k] == 2, m_st[k] == 3});
      chk($sformatf("act_id%0d", k), 32'(act_o[k]), 32'(m_act[k]));
      chk($sformatf("first_id%0d", k), 32'(first_o[k]), 32'(m_first[k]));
      chk($sformatf("evt%0d", k), evt_o[k], e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(rst, flt_in, mask, cw, cf);
    #1;
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int j = 0; j < n; j++) tick();
  endtask

  initial begin
    logic [31:0] ev;
    // Reset values
    rst = 1'b1; ticks(2); rst = 1'b0;
    chk("rst_state", 32'(st_o[0]), 32'd0);
    chk("rst_ids", {24'd0, act_o[0], first_o[0]}, 32'd0);
    chk("rst_evt", evt_o[0], 32'd0);

    // Short glitch on channel 3 never reaches the warning threshold
    flt_in = 4'b1000; ticks(2); flt_in = '0; ticks(2);
    chk("glitch_state", 32'(st_o[0]), 32'd0);
    ev = evt_o[0]; chk("glitch_evt3", 32'(ev[31:24]), 32'd0);

    // Channel 0 for 20 cycles: WARNING after edge 5, FAULT after edge 17
    flt_in = 4'b0001; ticks(4);
    chk("pre_warn", 32'(st_o[0]), 32'd0);
    tick();
    chk("warn_edge5", 32'(st_o[0]), 32'd1);
    ticks(11);
    chk("pre_fault", 32'(st_o[0]), 32'd1);
    tick();
    chk("fault_edge17", 32'(st_o[0]), 32'd2);
    chk("first_id_ch0", 32'(first_o[0]), 32'd1);
    ev = evt_o[0]; chk("evt0_one", 32'(ev[7:0]), 32'd1);
    ticks(3);
    flt_in = '0; cf = 1'b1; tick(); cf = 1'b0;
    chk("clear_fault", 32'(st_o[0]), 32'd0);
    chk("first_id_clr", 32'(first_o[0]), 32'd0);

    // Channel 1: WARNING, then auto-recovery after 8 clean cycles
    flt_in = 4'b0010; ticks(6); flt_in = '0; ticks(7);
    chk("recover_7", 32'(st_o[0]), 32'd1);
    tick();
    chk("recover_8", 32'(st_o[0]), 32'd0);
    // clear_warning refused while the channel is still above threshold
    flt_in = 4'b0010; ticks(5);
    cw = 1'b1; tick(); cw = 1'b0;
    chk("cw_refused", 32'(st_o[0]), 32'd1);
    flt_in = '0; tick();
    cw = 1'b1; tick(); cw = 1'b0;
    chk("cw_accepted", 32'(st_o[0]), 32'd0);

    // Channel 2 for 40 cycles: SHUTDOWN after edge 33, sticky until rst
    flt_in = 4'b0100; ticks(32);
    chk("pre_shut", 32'(st_o[0]), 32'd2);
    tick();
    chk("shut_edge33", 32'(st_o[0]), 32'd3);
    chk("shut_edge33_b", 32'(st_o[1]), 32'd3);
    ticks(7);
    flt_in = '0; cw = 1'b1; cf = 1'b1; ticks(3); cw = 1'b0; cf = 1'b0;
    chk("shut_sticky", 32'(st_o[0]), 32'd3);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst2_state", {27'd0, st_o[0], warn_o[0], fault_o[0], shut_o[0]}, 32'd0);
    chk("rst2_ids", {24'd0, act_o[0], first_o[0]}, 32'd0);
    chk("rst2_evt", evt_o[0], 32'd0);

    // Masked channel 0 stays quiet; unmasking restarts the run from zero
    mask = 4'b0001; flt_in = 4'b0001; ticks(50);
    chk("mask_state", 32'(st_o[0]), 32'd0);
    chk("mask_evt", evt_o[0], 32'd0);
    mask = '0; ticks(4);
    chk("unmask_4", 32'(st_o[0]), 32'd0);
    tick();
    chk("unmask_5", 32'(st_o[0]), 32'd1);
    ticks(15);
    flt_in = '0; cf = 1'b1; tick(); cf = 1'b0;

    // Channel 3 held: shutdown-capable instance shuts down, the other parks in FAULT
    flt_in = 4'b1000; ticks(100);
    chk("ch3_shut_en", 32'(st_o[0]), 32'd3);
    chk("ch3_no_shut", 32'(st_o[1]), 32'd2);
    flt_in = '0; rst = 1'b1; tick(); rst = 1'b0;

    // 300 short pulses on channel 1 saturate its event counter
    for (int p = 0; p < 300; p++) begin
      flt_in = 4'b0010; ticks(5); flt_in = '0; tick();
    end
    ev = evt_o[0]; chk("evt1_sat", 32'(ev[15:8]), 32'd255);
    ev = evt_o[1]; chk("evt1_sat_b", 32'(ev[15:8]), 32'd255);
    rst = 1'b1; tick(); rst = 1'b0;

    // Random bursts, masks, clears and occasional resets against the model
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(7) == 0)  flt_in[i] = ~flt_in[i];
        if ($urandom_range(63) == 0) mask[i]   = ~mask[i];
      end
      cw  = ($urandom_range(9) == 0);
      cf  = ($urandom_range(9) == 0);
      rst = ($urandom_range(499) == 0);
      tick();
    end
    rst = 1'b0; cw = 1'b0; cf = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
